// File: rtl/control_sequencer.sv
// control_sequencer: multicycle control state machine.
// Produces the state code for control decode plus status and counters.
module control_sequencer #(
  parameter int          CW          = 32,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    opcode,
  output logic [3:0]    state,
  output logic          halted,
  output logic          illegal,
  output logic          instrRetired,
  output logic [CW-1:0] instrCount,
  output logic [CW-1:0] cycleCount
);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_RF    = 4'd1,
    S_IMM2  = 4'd2,
    S_ALUR3 = 4'd3,
    S_ALUI3 = 4'd4,
    S_ALU4  = 4'd5,
    S_BR3   = 4'd6,
    S_MEM3  = 4'd7,
    S_LD4   = 4'd8,
    S_ST4   = 4'd9,
    S_LD5   = 4'd10,
    S_J3    = 4'd11,
    S_HALT  = 4'd12,
    S_ILL   = 4'd13
  } state_t;

  // The register is plain logic so that upset codes 14/15 stay representable.
  logic [3:0] st;
  logic [3:0] nxt;
  logic       is_store;
  logic       retire;

  // Next-state and retire decode from current state and opcode.
  always_comb begin
    nxt    = st;
    retire = 1'b0;
    case (st)
      S_IF:    nxt = S_RF;
      S_RF: begin
        if (opcode[5:4] == 2'b00)
          nxt = S_ALUR3;
        else if (opcode[5:4] == 2'b01)
          nxt = S_ALUI3;
        else if (opcode[5:3] == 3'b100)
          nxt = S_BR3;
        else if (opcode == 6'b101000)
          nxt = S_MEM3;
        else if (opcode == 6'b101001)
          nxt = S_MEM3;
        else if (opcode == 6'b110000)
          nxt = S_J3;
        else if (opcode == 6'b110001)
          nxt = S_IMM2;
        else if (opcode == HALT_OPCODE)
          nxt = S_HALT;
        else
          nxt = S_ILL;
      end
      S_ALUR3: nxt = S_ALU4;
      S_ALUI3: nxt = S_ALU4;
      S_MEM3:  nxt = is_store ? S_ST4 : S_LD4;
      S_LD4:   nxt = S_LD5;
      S_ALU4, S_LD5, S_ST4,
      S_BR3, S_J3, S_IMM2: begin
        nxt    = S_IF;
        retire = 1'b1;
      end
      S_HALT:  nxt = S_HALT;
      S_ILL:   nxt = S_ILL;
      default: nxt = S_ILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      st <= S_IF;
    else
      st <= nxt;
  end

  // Load/store selector latched while the opcode is first valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      is_store <= 1'b0;
    else if (st == S_RF)
      is_store <= opcode[0];
  end

  // Registered status flags and retire pulse track the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted       <= 1'b0;
      illegal      <= 1'b0;
      instrRetired <= 1'b0;
    end else begin
      halted       <= (nxt == S_HALT);
      illegal      <= (nxt == S_ILL);
      instrRetired <= retire;
    end
  end

  // Performance counters; cycles stop once the machine is stopped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrCount <= '0;
      cycleCount <= '0;
    end else begin
      if (retire)
        instrCount <= instrCount + 1'b1;
      if (st != S_HALT && st != S_ILL)
        cycleCount <= cycleCount + 1'b1;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed scoreboard bench for control_sequencer.
// Expected state/retire pairs are queued, then popped each cycle.
module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [3:0]  state;
  logic        halted;
  logic        illegal;
  logic        instrRetired;
  logic [31:0] instrCount;
  logic [31:0] cycleCount;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       ret;
  } exp_t;

  exp_t q[$];

  control_sequencer #(.CW(32), .HALT_OPCODE(6'b111111)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .state        (state),
    .halted       (halted),
    .illegal      (illegal),
    .instrRetired (instrRetired),
    .instrCount   (instrCount),
    .cycleCount   (cycleCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] s, input logic r);
    exp_t e;
    e.st  = s;
    e.ret = r;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk("state", {28'd0, state}, {28'd0, e.st});
      chk("retired", {31'd0, instrRetired}, {31'd0, e.ret});
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_retired", {31'd0, instrRetired}, 32'd0);
    chk("rst_icount", instrCount, 32'd0);
    chk("rst_ccount", cycleCount, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'b000000;
    @(negedge clk);
    do_reset();

    // R-type back to back
    opcode = 6'b000010;
    push(4'd0, 1'b0); push(4'd1, 1'b0);
    push(4'd3, 1'b0); push(4'd5, 1'b0);
    push(4'd0, 1'b1); push(4'd1, 1'b0);
    push(4'd3, 1'b0); push(4'd5, 1'b0);
    drain();
    chk("r_state", {28'd0, state}, 32'd0);
    chk("r_retired", {31'd0, instrRetired}, 32'd1);
    chk("r_icount", instrCount, 32'd2);

    // load, opcode disturbed during MEMORY_REF3
    opcode = 6'b101000;
    push(4'd0, 1'b1); push(4'd1, 1'b0);
    drain();
    opcode = 6'b000000;
    push(4'd7, 1'b0); push(4'd8, 1'b0); push(4'd10, 1'b0);
    drain();
    chk("ld_icount", instrCount, 32'd3);

    // store, opcode disturbed during MEMORY_REF3
    opcode = 6'b101001;
    push(4'd0, 1'b1); push(4'd1, 1'b0);
    drain();
    opcode = 6'b000000;
    push(4'd7, 1'b0); push(4'd9, 1'b0);
    drain();
    chk("st_icount", instrCount, 32'd4);

    // branch, jump, immediate injection
    opcode = 6'b100011;
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd6, 1'b0);
    drain();
    opcode = 6'b110000;
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd11, 1'b0);
    drain();
    opcode = 6'b110001;
    push(4'd0, 1'b1); push(4'd1, 1'b0); push(4'd2, 1'b0);
    drain();
    chk("bji_state", {28'd0, state}, 32'd0);
    chk("bji_retired", {31'd0, instrRetired}, 32'd1);
    chk("bji_icount", instrCount, 32'd7);
    chk("bji_ccount", cycleCount, 32'd26);

    // halt is sticky, cycle count freezes
    do_reset();
    opcode = 6'b111111;
    push(4'd0, 1'b0); push(4'd1, 1'b0);
    drain();
    opcode = 6'b000000;
    for (int i = 0; i < 20; i++) begin
      chk("halt_state", {28'd0, state}, 32'd12);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_retired", {31'd0, instrRetired}, 32'd0);
      chk("halt_ccount", cycleCount, 32'd2);
      @(negedge clk);
    end
    chk("halt_icount", instrCount, 32'd0);

    // undefined opcode traps to ILLEGAL
    do_reset();
    opcode = 6'b110010;
    push(4'd0, 1'b0); push(4'd1, 1'b0);
    drain();
    opcode = 6'b000010;
    for (int i = 0; i < 5; i++) begin
      chk("ill_state", {28'd0, state}, 32'd13);
      chk("ill_flag", {31'd0, illegal}, 32'd1);
      chk("ill_halted", {31'd0, halted}, 32'd0);
      chk("ill_ccount", cycleCount, 32'd2);
      @(negedge clk);
    end
    chk("ill_icount", instrCount, 32'd0);

    // upset to unused code 14
    do_reset();
    opcode = 6'b000010;
    force dut.st = 4'hE;
    #1;
    chk("upset_state", {28'd0, state}, 32'd14);
    release dut.st;
    @(posedge clk);
    #1;
    chk("upset_next", {28'd0, state}, 32'd13);
    chk("upset_illegal", {31'd0, illegal}, 32'd1);
    @(negedge clk);

    // reset in the middle of LOAD4
    do_reset();
    opcode = 6'b101000;
    push(4'd0, 1'b0); push(4'd1, 1'b0); push(4'd7, 1'b0);
    drain();
    chk("ld4_state", {28'd0, state}, 32'd8);
    chk("ld4_ccount", cycleCount, 32'd3);
    do_reset();
    push(4'd0, 1'b0); push(4'd1, 1'b0); push(4'd7, 1'b0);
    push(4'd8, 1'b0); push(4'd10, 1'b0); push(4'd0, 1'b1);
    drain();
    chk("ld_after_icount", instrCount, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
